// File: rtl/alu_slice_exec.sv
// Slice-serial ALU: executes add/sub/and/or/slt over WIDTH/SLICE cycles, LSB slice first.
// Operands are latched on start; result, zero and illegal are registered and held between operations.
module alu_slice_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [2:0]       ctrl_q;
  logic             carry_q, busy_q, done_q, zero_q, illegal_q;
  logic [CW-1:0]    cnt_q;

  logic [SLICE-1:0] a_k, b_k, b_op, slice_res;
  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] acc_nxt, final_res;
  logic             ovf, less, legal_in, sub_in;

  // Current slice datapath and the accumulator with this slice merged in.
  always_comb begin
    a_k  = SLICE'(a_q >> (32'(cnt_q) * SLICE));
    b_k  = SLICE'(b_q >> (32'(cnt_q) * SLICE));
    b_op = (ctrl_q == OP_SUB || ctrl_q == OP_SLT) ? ~b_k : b_k;
    sum  = {1'b0, a_k} + {1'b0, b_op} + (SLICE+1)'(carry_q);
    case (ctrl_q)
      OP_AND:  slice_res = a_k & b_k;
      OP_OR:   slice_res = a_k | b_k;
      default: slice_res = sum[SLICE-1:0];
    endcase
    acc_nxt = (acc_q & ~(WIDTH'({SLICE{1'b1}}) << (32'(cnt_q) * SLICE)))
            | (WIDTH'(slice_res) << (32'(cnt_q) * SLICE));
    // Signed compare: overflow when a and ~b agree in sign but the difference does not.
    ovf       = (a_q[WIDTH-1] == ~b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
    less      = acc_nxt[WIDTH-1] ^ ovf;
    final_res = (ctrl_q == OP_SLT) ? WIDTH'(less) : acc_nxt;
    legal_in  = (ctrl == OP_ADD) || (ctrl == OP_SUB) || (ctrl == OP_AND) ||
                (ctrl == OP_OR)  || (ctrl == OP_SLT);
    sub_in    = (ctrl == OP_SUB) || (ctrl == OP_SLT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      ctrl_q    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            ctrl_q  <= ctrl;
            carry_q <= sub_in;
            cnt_q   <= '0;
            acc_q   <= '0;
            if (legal_in) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              // Unknown opcode completes immediately without entering RUN.
              state_q   <= FIN;
              done_q    <= 1'b1;
              result_q  <= '0;
              zero_q    <= 1'b1;
              illegal_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= acc_nxt;
          carry_q <= sum[SLICE];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q   <= FIN;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            result_q  <= final_res;
            zero_q    <= (final_res == '0);
            illegal_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_slice_exec.sv
// Scoreboard bench for alu_slice_exec: directed vectors push expectations, a done-driven monitor checks them.
module tb_alu_slice_exec;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [2:0]  ctrl;
  logic [31:0] a, b;
  logic        busy, done, zero, illegal;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [31:0] last_res;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  alu_slice_exec #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"},  result, e.res);
        chk({e.name, "_zero"},    32'(zero), 32'(e.z));
        chk({e.name, "_illegal"}, 32'(illegal), 32'(e.ill));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] res, input logic z, input logic ill);
    exp_t e;
    e.name = name; e.res = res; e.z = z; e.ill = ill;
    e.cyc  = cyc + (ill ? 1 : 5);
    sb.push_back(e);
    last_res = res;
  endtask

  // Drive one start cycle, then scramble inputs (they may change after acceptance).
  task automatic issue(input string name, input logic [2:0] c, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] res, input logic z, input logic ill);
    ctrl = c; a = va; b = vb; start = 1'b1;
    push_exp(name, res, z, ill);
    @(negedge clk); #1;
    start = 1'b0; a = ~va; b = vb ^ 32'h5A5A_5A5A; ctrl = ~c;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
    // Outputs hold and done drops after the pulse.
    @(negedge clk); #1;
    chk({name, "_done_drop"}, 32'(done), 32'd0);
    chk({name, "_hold"}, result, last_res);
  endtask

  task automatic run(input string name, input logic [2:0] c, input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] res, input logic z, input logic ill);
    issue(name, c, va, vb, res, z, ill);
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; ctrl = 3'b000; a = '0; b = '0; last_res = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_result",  result, 32'd0);
    chk("rst_zero",    32'(zero), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    run("add_wrap",  3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0);
    run("add_zero",  3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    run("add_carry", 3'b010, 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0, 1'b0);
    run("sub_eq",    3'b110, 32'd5, 32'd5, 32'h0000_0000, 1'b1, 1'b0);
    run("sub_neg",   3'b110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run("and",       3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
    run("or",        3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0);
    run("slt_m1_1",  3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    run("slt_ovf0",  3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
    run("slt_ovf1",  3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run("slt_eq",    3'b111, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);

    // Illegal opcode: done one cycle after start, busy stays low.
    issue("illegal", 3'b011, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b1, 1'b1);
    chk("illegal_busy", 32'(busy), 32'd0);
    wait_done("illegal");
    chk("illegal_held", 32'(illegal), 32'd1);
    run("after_illegal", 3'b010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);

    // Start pulsed while busy must be ignored.
    issue("ignore", 3'b010, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("ignore_busy", 32'(busy), 32'd1);
    ctrl = 3'b001; a = 32'hAAAA_0000; b = 32'h0000_5555; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done("ignore");

    // Start held high through done: second op accepted in the done cycle.
    ctrl = 3'b110; a = 32'd100; b = 32'd1; start = 1'b1;
    push_exp("b2b_first", 32'd99, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    ctrl = 3'b000; a = 32'h0F0F_0F0F; b = 32'h00FF_FF00;
    push_exp("b2b_second", 32'h000F_0F00, 1'b0, 1'b0);
    @(negedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b");

    // Reset during RUN cycle 2 discards the operation.
    ctrl = 3'b010; a = 32'h1234_0000; b = 32'h0000_5678; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midrst_busy",    32'(busy), 32'd0);
    chk("midrst_done",    32'(done), 32'd0);
    chk("midrst_result",  result, 32'd0);
    chk("midrst_zero",    32'(zero), 32'd0);
    chk("midrst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    run("after_rst", 3'b010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
